// File: rtl/pc_fetch_reg.sv
// pc_fetch_reg: program-counter register with fetch handshake, misalignment trap and saturating fetch count
module pc_fetch_reg #(
  parameter int unsigned WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned STEP     = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] next_pc_in,
  input  logic             redirect,
  input  logic             stall,
  input  logic             fetch_ready,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus_step,
  output logic             fetch_valid,
  output logic             misalign_err,
  output logic [WIDTH-1:0] trap_addr,
  output logic [CNT_W-1:0] fetch_count
);
  typedef enum logic [1:0] {BOOT, FETCH, TRAP} state_t;
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);
  state_t state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d, trap_q, trap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic accept, take, mis;
  assign accept = (state_q == FETCH) & fetch_ready & ~stall;
  assign take   = (state_q == FETCH) & (redirect | accept);
  assign mis    = |(next_pc_in & ALIGN_MASK);
  // state register
  always_ff @(posedge clk)
    state_q <= rst ? BOOT : state_d;
  // next state: boot lasts one cycle, any misaligned target taken in FETCH traps until reset
  always_comb
    state_d = state_q == BOOT ? FETCH :
              state_q == FETCH ? ((take & mis) ? TRAP : FETCH) : TRAP;
  // datapath next values: count any accepted request even if it is redirected or traps
  always_comb begin
    pc_d   = (take & ~mis) ? next_pc_in : pc_q;
    trap_d = (take & mis) ? next_pc_in : trap_q;
    cnt_d  = (accept & ~&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  // datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      trap_q <= '0;
      cnt_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      trap_q <= trap_d;
      cnt_q  <= cnt_d;
    end
  end
  // outputs decode from state only, so fetch_ready never reaches fetch_valid combinationally
  always_comb begin
    fetch_valid  = state_q == FETCH;
    misalign_err = state_q == TRAP;
    pc           = pc_q;
    pc_plus_step = pc_q + WIDTH'(STEP);
    trap_addr    = trap_q;
    fetch_count  = cnt_q;
  end
endmodule

// File: tb/tb_pc_fetch_reg.sv
// tb_pc_fetch_reg: directed checks of reset, sequencing, backpressure, redirect, trap, wrap and saturation
module tb_pc_fetch_reg;
  logic clk = 0, rst = 1, redirect = 0, stall = 0, fetch_ready = 0;
  logic [31:0] next_pc_in = 0;
  logic [31:0] pc, pps, trap_addr, pc2, pps2, trap2;
  logic fv, err, fv2, err2;
  logic [15:0] cnt;
  logic [1:0] cnt2;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  pc_fetch_reg dut (.clk(clk), .rst(rst), .next_pc_in(next_pc_in), .redirect(redirect),
    .stall(stall), .fetch_ready(fetch_ready), .pc(pc), .pc_plus_step(pps), .fetch_valid(fv),
    .misalign_err(err), .trap_addr(trap_addr), .fetch_count(cnt));
  pc_fetch_reg #(.CNT_W(2)) dut2 (.clk(clk), .rst(rst), .next_pc_in(next_pc_in), .redirect(redirect),
    .stall(stall), .fetch_ready(fetch_ready), .pc(pc2), .pc_plus_step(pps2), .fetch_valid(fv2),
    .misalign_err(err2), .trap_addr(trap2), .fetch_count(cnt2));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic r, input logic rd, input logic st, input logic [31:0] n);
    redirect = r;
    fetch_ready = rd;
    stall = st;
    next_pc_in = n;
  endtask
  task automatic do_reset();
    drive(0, 0, 0, 0);
    rst = 1;
    cyc();
    rst = 0;
  endtask
  initial begin
    do_reset();
    chk("rst_pc", pc, 0);
    chk("rst_valid", fv, 0);
    chk("rst_err", err, 0);
    chk("rst_trap", trap_addr, 0);
    chk("rst_cnt", cnt, 0);
    cyc();
    chk("boot_valid", fv, 1);
    chk("boot_pc", pc, 0);
    chk("pps0", pps, 4);
    for (int i = 1; i <= 4; i++) begin
      drive(0, 1, 0, 32'(4 * i));
      cyc();
      chk("seq_pc", pc, 64'(4 * i));
    end
    chk("seq_cnt", cnt, 4);
    drive(1, 0, 0, 32'h8);
    cyc();
    chk("bp_setup_pc", pc, 8);
    for (int i = 0; i < 6; i++) begin
      drive(0, i >= 3, i >= 3, 32'h40);
      cyc();
      chk("bp_pc", pc, 8);
      chk("bp_valid", fv, 1);
      chk("bp_cnt", cnt, 4);
    end
    drive(1, 0, 0, 32'h100);
    cyc();
    chk("redir_pc", pc, 32'h100);
    chk("redir_cnt", cnt, 4);
    drive(1, 1, 0, 32'h200);
    cyc();
    chk("redir_acc_pc", pc, 32'h200);
    chk("redir_acc_cnt", cnt, 5);
    drive(1, 0, 0, 32'h102);
    cyc();
    for (int i = 0; i < 6; i++) begin
      chk("trap_err", err, 1);
      chk("trap_addr", trap_addr, 32'h102);
      chk("trap_valid", fv, 0);
      chk("trap_pc", pc, 32'h200);
      chk("trap_cnt", cnt, 5);
      drive(i[0], 1, 0, 32'h300);
      cyc();
    end
    do_reset();
    chk("trap_rst_pc", pc, 0);
    chk("trap_rst_err", err, 0);
    chk("trap_rst_addr", trap_addr, 0);
    cyc();
    drive(0, 1, 0, 32'h6);
    cyc();
    chk("acc_mis_err", err, 1);
    chk("acc_mis_addr", trap_addr, 6);
    chk("acc_mis_pc", pc, 0);
    chk("acc_mis_cnt", cnt, 1);
    do_reset();
    cyc();
    drive(1, 0, 0, 32'hFFFF_FFFC);
    cyc();
    chk("wrap_pc", pc2, 32'hFFFF_FFFC);
    chk("wrap_pps", pps2, 0);
    chk("wrap_cnt0", cnt2, 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 32'(4 * i));
      cyc();
      chk("wrap_seq_pc", pc2, 64'(4 * i));
      chk("sat_cnt", cnt2, i >= 2 ? 3 : i + 1);
    end
    chk("wrap_err", err2, 0);
    chk("wrap_valid", fv2, 1);
    chk("nosat_cnt", cnt, 5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
